// File: rtl/uart_pkg.sv
// Shared UART register map, LSR status bits, and the register-arbiter FSM encodings and types.
package uart_pkg;
  localparam logic [2:0] UART_RX  = 3'd0;
  localparam logic [2:0] UART_TX  = 3'd0;
  localparam logic [2:0] UART_IER = 3'd1;
  localparam logic [2:0] UART_FCR = 3'd2;
  localparam logic [2:0] UART_LCR = 3'd3;
  localparam logic [2:0] UART_MCR = 3'd4;
  localparam logic [2:0] UART_LSR = 3'd5;
  localparam logic [2:0] UART_MSR = 3'd6;
  localparam logic [2:0] UART_SCR = 3'd7;
  // Divisor latches overlay RX/TX and IER while LCR.DLAB is set
  localparam logic [2:0] UART_DLL = 3'd0;
  localparam logic [2:0] UART_DLM = 3'd1;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef struct packed {
    logic       owner;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
  } acc_t;
endpackage

// File: rtl/uart_reg_arbiter_if.sv
// Two requester ports plus the shared UART register bus; slave = arbiter side, master = requesters/UART.
interface uart_reg_arbiter_if;
  import uart_pkg::*;

  logic       req_valid_0, req_valid_1;
  logic       req_ready_0, req_ready_1;
  logic       req_we_0, req_we_1;
  logic [2:0] req_addr_0, req_addr_1;
  logic [7:0] req_wdata_0, req_wdata_1;
  logic       req_lock_0, req_lock_1;
  logic       rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_rdata_0, rsp_rdata_1;
  logic       uart_cs, uart_wr, uart_rd;
  logic [2:0] uart_a;
  logic [7:0] uart_din;
  logic [7:0] uart_dout;
  logic       busy;

  modport slave (
    input  req_valid_0, req_valid_1, req_we_0, req_we_1, req_addr_0, req_addr_1,
           req_wdata_0, req_wdata_1, req_lock_0, req_lock_1, uart_dout,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
           uart_cs, uart_wr, uart_rd, uart_a, uart_din, busy
  );

  modport master (
    output req_valid_0, req_valid_1, req_we_0, req_we_1, req_addr_0, req_addr_1,
           req_wdata_0, req_wdata_1, req_lock_0, req_lock_1, uart_dout,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
           uart_cs, uart_wr, uart_rd, uart_a, uart_din, busy
  );
endinterface

// File: rtl/uart_reg_arbiter_rr_arb2.sv
// Two-way round-robin selector, combinational grant while enabled; a grant carrying
// lock pins selection to that requester until it is granted again without lock.
module rr_arb2
  import uart_pkg::*;
(
  input  logic       clk_33M,
  input  logic       rstn,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt,
  output logic       locked
);
  logic last;

  // last starts at 1 so requester 0 wins the first contention
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (locked)     gnt[last]  = req[last];
      else if (&req)  gnt[~last] = 1'b1;
      else            gnt        = req;
    end
  end

  always_ff @(posedge clk_33M or negedge rstn) begin
    if (!rstn) begin
      last   <= 1'b1;
      locked <= 1'b0;
    end else if (|gnt) begin
      last   <= gnt[1];
      locked <= lock;
    end
  end
endmodule

// File: rtl/uart_reg_arbiter.sv
// Arbitrates two requesters onto one UART register bus. Write: rsp 3 cycles after handshake;
// read: 3+RD_CAPTURE. req_ready only in IDLE for the selected requester; the other stalls.
module uart_reg_arbiter
  import uart_pkg::*;
#(
  parameter int RD_CAPTURE = 1
) (
  input logic               clk_33M,
  input logic               rstn,
  uart_reg_arbiter_if.slave bus
);
  logic [2:0] state;
  acc_t       acc;
  logic [1:0] cap_cnt;
  logic [7:0] rdata;
  logic [1:0] gnt;
  logic       locked, sel_lock, idle, rel;

  assign idle     = (state == ST_IDLE);
  assign rel      = (state == ST_RELEASE);
  assign sel_lock = gnt[1] ? bus.req_lock_1 : bus.req_lock_0;

  rr_arb2 u_arb (
    .clk_33M (clk_33M),
    .rstn    (rstn),
    .en      (idle),
    .req     ({bus.req_valid_1, bus.req_valid_0}),
    .lock    (sel_lock),
    .gnt     (gnt),
    .locked  (locked)
  );

  always_ff @(posedge clk_33M or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cap_cnt <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|gnt) begin
          acc.owner <= gnt[1];
          acc.we    <= gnt[1] ? bus.req_we_1    : bus.req_we_0;
          acc.addr  <= gnt[1] ? bus.req_addr_1  : bus.req_addr_0;
          acc.wdata <= gnt[1] ? bus.req_wdata_1 : bus.req_wdata_0;
          state     <= ST_SETUP;
        end
        ST_SETUP:  state <= ST_STROBE;
        ST_STROBE: begin
          cap_cnt <= '0;
          state   <= acc.we ? ST_RELEASE : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (cap_cnt == 2'(RD_CAPTURE - 1)) begin
            rdata <= bus.uart_dout;
            state <= ST_RELEASE;
          end else begin
            cap_cnt <= cap_cnt + 2'd1;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready_0 = gnt[0];
  assign bus.req_ready_1 = gnt[1];

  // Strobes decode straight from registered state so reset drops them without a clock
  assign bus.uart_cs  = (state == ST_SETUP) | (state == ST_STROBE) | (state == ST_CAPTURE);
  assign bus.uart_wr  = (state == ST_STROBE) & acc.we;
  assign bus.uart_rd  = ((state == ST_STROBE) | (state == ST_CAPTURE)) & ~acc.we;
  assign bus.uart_a   = acc.addr;
  assign bus.uart_din = acc.wdata;

  assign bus.rsp_valid_0 = rel & ~acc.owner;
  assign bus.rsp_valid_1 = rel &  acc.owner;
  assign bus.rsp_rdata_0 = (rel & ~acc.owner & ~acc.we) ? rdata : 8'h00;
  assign bus.rsp_rdata_1 = (rel &  acc.owner & ~acc.we) ? rdata : 8'h00;

  assign bus.busy = ~idle | locked;
endmodule

// File: doc/uart_reg_arbiter.md
UART_REG_ARBITER -- requirements
Module: uart_reg_arbiter

Interface
REQ-001 SHALL have parameter RD_CAPTURE, default 1: cycles from uart_rd rising to uart_dout capture (range 1-3).
REQ-002 SHALL have port clk_33M  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid_0/1  in  1  requester n has a pending register access.
REQ-005 SHALL have ports req_ready_0/1  out  1  access accepted this cycle; combinational.
REQ-006 SHALL have ports req_we_0/1  in  1  1=write, 0=read.
REQ-007 SHALL have ports req_addr_0/1  in  3  UART register address.
REQ-008 SHALL have ports req_wdata_0/1  in  8  write data.
REQ-009 SHALL have ports req_lock_0/1  in  1  keep the grant after this access, for atomic sequences such as DLAB set, DLL, DLM, DLAB clear.
REQ-010 SHALL have ports rsp_valid_0/1  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports rsp_rdata_0/1  out  8  read data; valid only with rsp_valid, 0 for writes.
REQ-012 SHALL have ports uart_cs, uart_wr, uart_rd  out  1  UART bus strobes.
REQ-013 SHALL have ports uart_a  out  3  and uart_din  out  8  UART address and write data.
REQ-014 SHALL have port uart_dout  in  8  UART read data.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE, or while a lock is held.

Function
REQ-016 SHALL run an FSM with states IDLE, SETUP, STROBE, CAPTURE and RELEASE.
REQ-017 Handshake SHALL occur on req_valid_n & req_ready_n; req_ready SHALL be high only in IDLE and only for the selected requester, never for both.
REQ-018 Requester obligations: hold valid/we/addr/wdata/lock stable until ready; the block SHALL latch them on the handshake.
REQ-019 Selection SHALL be round-robin: if both are valid, grant the requester not granted last; the pointer after reset SHALL favour requester 0.
REQ-020 Lock: if the accepted access has lock=1, only the same requester SHALL be selectable in IDLE until it completes an access with lock=0; the other requester stays stalled meanwhile.
REQ-021 Write timing, with the handshake at cycle T:
- T+1 SETUP: cs=1, uart_a and uart_din driven.
- T+2 STROBE: wr=1.
- T+3 RELEASE: cs=0, wr=0, rsp_valid pulse; return to IDLE.
- T+4: a new handshake is possible.
REQ-022 Read timing, with the handshake at cycle T:
- T+1 SETUP: cs=1, uart_a driven.
- T+2 STROBE: rd=1.
- CAPTURE holds rd=1 for RD_CAPTURE cycles, then registers uart_dout.
- Next cycle RELEASE: cs=0, rd=0, rsp_valid with the captured rsp_rdata.
- RD_CAPTURE=1 gives rsp_valid at T+4.
REQ-023 uart_a/uart_din SHALL be stable from SETUP through RELEASE; uart_wr and uart_rd SHALL never be high together, and never high while cs=0.
REQ-024 rsp_valid/rsp_rdata SHALL go only to the requester that issued the access.
REQ-025 A requester dropping valid without a handshake SHALL be legal and SHALL have no effect.
REQ-026 Simultaneous events: an access completing in RELEASE while the other requester is valid SHALL grant the other one at the next IDLE cycle (round-robin), unless a lock is held.

Reset
REQ-027 rstn low SHALL force the following immediately, including mid-access:
- FSM to IDLE.
- uart_cs/wr/rd=0, uart_a=0, uart_din=0.
- rsp_valid=0, rsp_rdata=0, busy=0.
- Lock cleared; round-robin pointer favouring requester 0.
REQ-028 The first handshake SHALL be possible in the first cycle after rstn rises.

Structure
REQ-029 UART register addresses (RX/TX, IER, FCR, LCR, MCR, LSR, MSR, SCR, DLL, DLM), LSR_DR, LSR_THRE and the FSM state encodings SHALL live in a shared package uart_pkg.
REQ-030 One sub-module, rr_arb2, SHALL be used: a 2-way round-robin selector with lock input.

Verification
REQ-031 Single write, req0 (LCR, 0x83): uart_cs high T+1..T+2; uart_wr high only at T+2; uart_a=3, uart_din=0x83; rsp_valid_0 at T+3.
REQ-032 Single read, req1 (LSR) with uart_dout=0x60, RD_CAPTURE=1: uart_rd high T+2..T+3; rsp_valid_1 at T+4 with rsp_rdata_1=0x60.
REQ-033 Both valid continuously, with writes: grants alternate 0,1,0,1; no requester waits more than one access.
REQ-034 Locked sequence: req0 issues LCR=0x83, DLL=0x11, DLM=0x00 with lock=1, then LCR=0x03 with lock=0, while req1 is valid throughout: req1 is granted only after the fourth access completes.
REQ-035 rstn asserted at read STROBE: uart_cs/uart_rd fall without waiting for a clock; no rsp_valid; after release, req1 alone is granted on its first valid cycle.
